// File: rtl/input_word_unpacker_pkg.sv
// Shared input-layer definitions: FSM state encodings, sample mode constants
// and the per-mode lane count derived from the memory word width.
package input_word_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_INT8 = 1'b1;
  localparam logic MODE_FP16 = 1'b0;

  // Number of INT8 samples packed in one word.
  function automatic int lanes_int8(input int word_w);
    return word_w / 8;
  endfunction

  // Number of FP16 samples packed in one word.
  function automatic int lanes_fp16(input int word_w);
    return word_w / 16;
  endfunction

  // Lane index width; sized for the larger (INT8) lane count.
  function automatic int lane_idx_w(input int word_w);
    return (word_w / 8 > 1) ? $clog2(word_w / 8) : 1;
  endfunction

endpackage

// File: rtl/input_word_unpacker_lane_select.sv
// Combinational lane mux: picks one byte (sign-extended) or one half-word
// out of the held memory word according to lane index and mode.
module input_lane_select
  import input_word_unpacker_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int LANE_W = 3
) (
  input  logic [WORD_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic              mode_int8,
  output logic [15:0]       sample
);

  // Two's-complement widening of an INT8 byte to 16 bits.
  function automatic logic signed [15:0] sign_ext8(input logic signed [7:0] b);
    logic signed [15:0] r;
    r = b;
    return r;
  endfunction

  // Select the addressed lane; INT8 lanes are bytes, FP16 lanes are half-words.
  always_comb begin
    sample = '0;
    if (mode_int8 == MODE_INT8) begin
      for (int i = 0; i < WORD_W / 8; i++) begin
        if (lane == LANE_W'(i)) sample = sign_ext8(word[i*8 +: 8]);
      end
    end else begin
      for (int i = 0; i < WORD_W / 16; i++) begin
        if (lane == LANE_W'(i)) sample = word[i*16 +: 16];
      end
    end
  end

endmodule

// File: rtl/input_word_unpacker.sv
// Input-layer fetch stage: accepts wide memory words over valid/ready and
// serialises them into one 16-bit sample per cycle for int2float16, tagging
// each sample with the cast flag and counting samples per frame.
module input_word_unpacker
  import input_word_unpacker_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              mode_int8,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              out_ready,
  output logic              sample_valid,
  output logic [15:0]       sample_data,
  output logic              sample_cast,
  output logic              frame_done,
  output logic              busy
);

  localparam int LANE_W    = lane_idx_w(WORD_W);
  localparam int LANES_I8  = lanes_int8(WORD_W);
  localparam int LANES_F16 = lanes_fp16(WORD_W);

  state_t state, state_next;

  logic [WORD_W-1:0] hold_p0;
  logic [LANE_W-1:0] lane_p0;
  logic [LEN_W-1:0]  remaining_p0;
  logic              mode_p0;

  logic [LANE_W-1:0] lane_max;
  logic              take;
  logic              accept;
  logic              last_lane;
  logic              last_sample;

  assign lane_max    = (mode_p0 == MODE_INT8) ? LANE_W'(LANES_I8 - 1) : LANE_W'(LANES_F16 - 1);
  assign take        = sample_valid & out_ready;
  assign accept      = word_valid & word_ready;
  assign last_lane   = (lane_p0 == lane_max);
  assign last_sample = (remaining_p0 == LEN_W'(1));
  assign sample_cast = mode_p0;

  input_lane_select #(
    .WORD_W (WORD_W),
    .LANE_W (LANE_W)
  ) u_lane_select (
    .word      (hold_p0),
    .lane      (lane_p0),
    .mode_int8 (mode_p0),
    .sample    (sample_data)
  );

  // State register; reset aborts any frame in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_next = (frame_len != '0) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        if (word_valid) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (take) begin
          if (last_sample)    state_next = ST_DONE;
          else if (last_lane) state_next = word_valid ? ST_EMIT : ST_LOAD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; word_ready in EMIT only on the take of the last lane with
  // samples still to come, so the next word follows without a bubble.
  always_comb begin
    sample_valid = 1'b0;
    word_ready   = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    case (state)
      ST_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_EMIT: begin
        sample_valid = 1'b1;
        busy         = 1'b1;
        word_ready   = out_ready & last_lane & ~last_sample;
      end
      ST_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Holding register, lane index, remaining count and latched mode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_p0      <= '0;
      lane_p0      <= '0;
      remaining_p0 <= '0;
      mode_p0      <= 1'b0;
    end else begin
      if (state == ST_IDLE && frame_start) begin
        remaining_p0 <= frame_len;
        mode_p0      <= mode_int8;
      end
      if (take) begin
        remaining_p0 <= remaining_p0 - LEN_W'(1);
        if (!last_lane) lane_p0 <= lane_p0 + LANE_W'(1);
      end
      // A newly accepted word always restarts at lane 0.
      if (accept) begin
        hold_p0 <= word_data;
        lane_p0 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_input_word_unpacker.sv
// Directed bench for input_word_unpacker: INT8/FP16 serialisation, no-bubble
// word chaining, partial last word, stalls, empty frame, ignored restarts and
// mid-frame reset.
module tb_input_word_unpacker;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [15:0] frame_len;
  logic        mode_int8;
  logic        word_valid;
  logic [63:0] word_data;
  logic        word_ready;
  logic        out_ready;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_cast;
  logic        frame_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] W1  = 64'h807F_0201_FF00_7F80;
  localparam logic [63:0] W2A = 64'h4400_3C00_BC00_0000;
  localparam logic [63:0] W2B = 64'h7BFF_FC00_0001_8000;

  logic [15:0] exp1 [8] = '{16'hFF80, 16'h007F, 16'h0000, 16'hFFFF,
                            16'h0001, 16'h0002, 16'h007F, 16'hFF80};
  logic [15:0] exp2 [8] = '{16'h0000, 16'hBC00, 16'h3C00, 16'h4400,
                            16'h8000, 16'h0001, 16'hFC00, 16'h7BFF};
  logic        rdy4 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] dat4 [6] = '{16'h0000, 16'hBC00, 16'hBC00, 16'hBC00, 16'h3C00, 16'h4400};
  logic        wr4  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  input_word_unpacker #(.WORD_W(64), .LEN_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .frame_len    (frame_len),
    .mode_int8    (mode_int8),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .out_ready    (out_ready),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_cast  (sample_cast),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; frame_start = 1'b0; frame_len = '0; mode_int8 = 1'b0;
    word_valid = 1'b0; word_data = '0; out_ready = 1'b0;
    tick(); tick();
    #1;
    chk1("rst_sample_valid", sample_valid, 1'b0);
    chk16("rst_sample_data", sample_data, 16'h0000);
    chk1("rst_sample_cast", sample_cast, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_word_ready", word_ready, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: INT8 single word, eight samples
    frame_start = 1'b1; frame_len = 16'd8; mode_int8 = 1'b1; out_ready = 1'b1;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W1;
    #1;
    chk1("t1_load_busy", busy, 1'b1);
    chk1("t1_load_ready", word_ready, 1'b1);
    chk1("t1_load_valid", sample_valid, 1'b0);
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("t1_valid%0d", i), sample_valid, 1'b1);
      chk16($sformatf("t1_data%0d", i), sample_data, exp1[i]);
      chk1($sformatf("t1_cast%0d", i), sample_cast, 1'b1);
      chk1($sformatf("t1_wready%0d", i), word_ready, 1'b0);
      tick();
    end
    #1;
    chk1("t1_done", frame_done, 1'b1);
    chk1("t1_done_busy", busy, 1'b0);
    chk1("t1_done_valid", sample_valid, 1'b0);
    tick();
    #1;
    chk1("t1_done_pulse_end", frame_done, 1'b0);

    // 2: FP16 two back-to-back words, no bubble
    frame_start = 1'b1; frame_len = 16'd8; mode_int8 = 1'b0;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W2A;
    tick();
    word_data = W2B;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) word_valid = 1'b0;
      #1;
      chk1($sformatf("t2_valid%0d", i), sample_valid, 1'b1);
      chk16($sformatf("t2_data%0d", i), sample_data, exp2[i]);
      chk1($sformatf("t2_cast%0d", i), sample_cast, 1'b0);
      chk1($sformatf("t2_wready%0d", i), word_ready, i == 3);
      tick();
    end
    #1;
    chk1("t2_done", frame_done, 1'b1);
    tick();

    // 3: INT8 partial word, upper lanes discarded
    frame_start = 1'b1; frame_len = 16'd5; mode_int8 = 1'b1;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk16($sformatf("t3_data%0d", i), sample_data, exp1[i]);
      chk1($sformatf("t3_wready%0d", i), word_ready, 1'b0);
      tick();
    end
    #1;
    chk1("t3_done", frame_done, 1'b1);
    chk1("t3_done_wready", word_ready, 1'b0);
    tick();
    #1;
    chk1("t3_idle_wready", word_ready, 1'b0);
    chk1("t3_idle_done", frame_done, 1'b0);
    word_valid = 1'b0;

    // 4: stalls mid-word, then a late second word
    frame_start = 1'b1; frame_len = 16'd8; mode_int8 = 1'b0;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W2A;
    tick();
    word_valid = 1'b0; word_data = W2B;
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy4[i];
      #1;
      chk1($sformatf("t4_valid%0d", i), sample_valid, 1'b1);
      chk16($sformatf("t4_data%0d", i), sample_data, dat4[i]);
      chk1($sformatf("t4_wready%0d", i), word_ready, wr4[i]);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("t4_wait_valid%0d", k), sample_valid, 1'b0);
      chk1($sformatf("t4_wait_wready%0d", k), word_ready, 1'b1);
      tick();
    end
    word_valid = 1'b1;
    #1;
    chk1("t4_load_valid", sample_valid, 1'b0);
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk16($sformatf("t4_data2_%0d", i), sample_data, exp2[4+i]);
      tick();
    end
    #1;
    chk1("t4_done", frame_done, 1'b1);
    tick();

    // 5: empty frame, then restart attempts while busy
    frame_start = 1'b1; frame_len = 16'd0; mode_int8 = 1'b1;
    tick();
    frame_start = 1'b0;
    #1;
    chk1("t5_empty_done", frame_done, 1'b1);
    chk1("t5_empty_wready", word_ready, 1'b0);
    chk1("t5_empty_busy", busy, 1'b0);
    tick();
    #1;
    chk1("t5_empty_done_end", frame_done, 1'b0);
    chk1("t5_empty_wready2", word_ready, 1'b0);
    frame_start = 1'b1; frame_len = 16'd3; mode_int8 = 1'b1;
    tick();
    frame_len = 16'd1; mode_int8 = 1'b0; word_valid = 1'b1; word_data = W1;
    #1;
    chk1("t5_busy", busy, 1'b1);
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) frame_start = 1'b0;
      #1;
      chk16($sformatf("t5_data%0d", i), sample_data, exp1[i]);
      chk1($sformatf("t5_cast%0d", i), sample_cast, 1'b1);
      chk1($sformatf("t5_done_early%0d", i), frame_done, 1'b0);
      tick();
    end
    #1;
    chk1("t5_done", frame_done, 1'b1);
    tick();
    #1;
    chk1("t5_idle_busy", busy, 1'b0);

    // 6: reset at sample 3 of 8, then a normal frame
    frame_start = 1'b1; frame_len = 16'd8; mode_int8 = 1'b1;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk16($sformatf("t6_data%0d", i), sample_data, exp1[i]);
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk16("t6_data3", sample_data, exp1[3]);
    tick();
    reset_n = 1'b1;
    #1;
    chk1("t6_rst_valid", sample_valid, 1'b0);
    chk16("t6_rst_data", sample_data, 16'h0000);
    chk1("t6_rst_cast", sample_cast, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_done", frame_done, 1'b0);
    chk1("t6_rst_wready", word_ready, 1'b0);
    tick();
    #1;
    chk1("t6_no_done", frame_done, 1'b0);
    frame_start = 1'b1; frame_len = 16'd2; mode_int8 = 1'b1;
    tick();
    frame_start = 1'b0; word_valid = 1'b1; word_data = W1;
    #1;
    chk1("t6_restart_wready", word_ready, 1'b1);
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk16($sformatf("t6_restart_data%0d", i), sample_data, exp1[i]);
      tick();
    end
    #1;
    chk1("t6_restart_done", frame_done, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
